sram_read_ctrl: RTL and testbench

Read-path sequencer and output register for the mixed-signal SRAM macro. Accepts one read request at a time, drives row precharge, one-hot wordline select and sense-amp enable in a fixed cycle schedule, then captures the column sense-amplifier digital outputs into a held output register. The output register is presented through a valid/ready handshake. The block sits directly downstream of the per-column differential sense amplifiers and upstream of the macro's read data port.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/row_decoder.sv | 23 ++
 rtl/sram_read_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_read_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and default geometry for the SRAM read path
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DEV,
        SENSE,
        OUT
    } rd_state_e;

    localparam int SRAM_COLS       = 16;
    localparam int SRAM_ROWS       = 16;
    localparam int SRAM_PRE_CYCLES = 2;
    localparam int SRAM_DEV_CYCLES = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/row_decoder.sv
// rtl/row_decoder.sv - enabled address to one-hot wordline decoder, all-zero when out of range
module row_decoder
    import sram_pkg::*;
#(
    parameter int ROWS = SRAM_ROWS,
    parameter int AW   = $clog2(SRAM_ROWS)
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [ROWS-1:0] onehot
);

    // Addresses at or beyond ROWS match no output bit, so they decode to zero
    always_comb begin
        onehot = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (en && (addr == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_read_ctrl.sv
// rtl/sram_read_ctrl.sv - SRAM read sequencer and held output register (SRAM_RD_PARITY_EN adds rd_par)
module sram_read_ctrl
    import sram_pkg::*;
#(
    parameter int COLS       = SRAM_COLS,
    parameter int ROWS       = SRAM_ROWS,
    parameter int PRE_CYCLES = SRAM_PRE_CYCLES,
    parameter int DEV_CYCLES = SRAM_DEV_CYCLES,
    parameter int AW         = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    output logic            precharge_en,
    output logic [ROWS-1:0] wl_sel,
    output logic            sae,
    input  logic [COLS-1:0] preout,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [COLS-1:0] rd_data
`ifdef SRAM_RD_PARITY_EN
    ,
    output logic            rd_par
`endif
);

    localparam int CW = $clog2(max_int(PRE_CYCLES, DEV_CYCLES)) + 1;
    localparam logic [CW-1:0] PRE_LOAD = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] DEV_LOAD = CW'(DEV_CYCLES - 1);

    rd_state_e       state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic            addr_ok;
    logic [ROWS-1:0] dec_onehot;
    logic            dec_en;

    // Decode is only consumed on the PRE->DEV transition edge
    assign dec_en = (state == PRE) && (cnt == '0);

    row_decoder #(
        .ROWS (ROWS),
        .AW   (AW)
    ) u_row_decoder (
        .en     (dec_en),
        .addr   (addr_q),
        .onehot (dec_onehot)
    );

    // Read schedule FSM; every array control and handshake output is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            addr_ok      <= 1'b0;
            req_ready    <= 1'b0;
            precharge_en <= 1'b0;
            wl_sel       <= '0;
            sae          <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
`ifdef SRAM_RD_PARITY_EN
            rd_par       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        addr_q       <= req_addr;
                        addr_ok      <= ({1'b0, req_addr} < (AW + 1)'(ROWS));
                        cnt          <= PRE_LOAD;
                        precharge_en <= 1'b1;
                        state        <= PRE;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        precharge_en <= 1'b0;
                        wl_sel       <= dec_onehot;
                        cnt          <= DEV_LOAD;
                        state        <= DEV;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DEV: begin
                    if (cnt == '0) begin
                        sae   <= 1'b1;
                        state <= SENSE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SENSE: begin
                    sae      <= 1'b0;
                    wl_sel   <= '0;
                    rd_valid <= 1'b1;
                    rd_data  <= addr_ok ? preout : '0;
`ifdef SRAM_RD_PARITY_EN
                    rd_par   <= addr_ok & (^preout);
`endif
                    state    <= OUT;
                end
                OUT: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    precharge_en <= 1'b0;
                    wl_sel       <= '0;
                    sae          <= 1'b0;
                    rd_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_ctrl.sv
// tb/tb_sram_read_ctrl.sv - directed scoreboard bench for sram_read_ctrl
module tb_sram_read_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_addr = '0;
    logic        precharge_en;
    logic [15:0] wl_sel;
    logic        sae;
    logic [15:0] preout = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_data;
`ifdef SRAM_RD_PARITY_EN
    logic        rd_par;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int t0 = 0;
    logic [16:0] sb[$];

    sram_read_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .precharge_en (precharge_en),
        .wl_sel       (wl_sel),
        .sae          (sae),
        .preout       (preout),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data)
`ifdef SRAM_RD_PARITY_EN
        ,
        .rd_par       (rd_par)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read: request, cycle-by-cycle schedule check, optional hold in OUT, handshake
    task automatic do_read(input logic [3:0] addr, input logic [15:0] pv, input int hold);
        int n;
        logic [15:0] exp_wl;
        logic [16:0] exp_e;
        n = 0;
        exp_e = 'x;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_req", 32'(req_ready), 32'd1);
        exp_wl    = 16'd1 << addr;
        req_valid = 1'b1;
        req_addr  = addr;
        rd_ready  = (hold == 0);
        preout    = 16'($urandom);
        sb.push_back({^pv, pv});
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("precharge_en", 32'(precharge_en), 32'(k <= 2));
            chk("wl_sel", 32'(wl_sel), (k >= 3 && k <= 6) ? 32'(exp_wl) : 32'd0);
            chk("sae", 32'(sae), 32'(k == 6));
            chk("rd_valid", 32'(rd_valid), 32'(k == 7));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (k == 7 && rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    exp_e = sb.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(exp_e[15:0]));
`ifdef SRAM_RD_PARITY_EN
                    chk("rd_par", 32'(rd_par), 32'(exp_e[16]));
`endif
                end
            end
            preout = (k == 6) ? pv : 16'($urandom);
        end
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk);
            #1;
            req_valid = (h == 3);
            req_addr  = 4'($urandom);
            preout    = 16'($urandom);
            @(negedge clk);
            chk("hold_rd_data", 32'(rd_data), 32'(exp_e[15:0]));
            chk("hold_rd_valid", 32'(rd_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_precharge", 32'(precharge_en), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rd_ready  = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        chk("post_rd_valid", 32'(rd_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_precharge", 32'(precharge_en), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_precharge", 32'(precharge_en), 32'd0);
        chk("rst_wl_sel", 32'(wl_sel), 32'd0);
        chk("rst_sae", 32'(sae), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef SRAM_RD_PARITY_EN
        chk("rst_rd_par", 32'(rd_par), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);
        chk("idle_wl_sel", 32'(wl_sel), 32'd0);

        // Basic read
        do_read(4'd5, 16'hA5C3, 0);

        // Held output with toggling preout and ignored request
        do_read(4'd5, 16'hA5C3, 10);

        // Back-to-back reads at the row extremes
        do_read(4'd0, 16'h1357, 0);
        t0 = acc_cyc;
        do_read(4'd15, 16'hFEDC, 0);
        chk("b2b_spacing", 32'(acc_cyc - t0), 32'd8);

        // Reset during DEV
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 4'd9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("dev_wl_sel", 32'(wl_sel), 32'h0200);
        #2 rst_n = 1'b0;
        #1;
        chk("async_wl_sel", 32'(wl_sel), 32'd0);
        chk("async_sae", 32'(sae), 32'd0);
        chk("async_precharge", 32'(precharge_en), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd0);
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("after_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("after_rst_wl_sel", 32'(wl_sel), 32'd0);
        do_read(4'd3, 16'h1234, 0);

        // Parity patterns
        do_read(4'd7, 16'h0007, 0);
        do_read(4'd2, 16'h0003, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
